urv_timer_irq: RTL and testbench

Programmable compare/interrupt controller for the core timer. It watches the 40-bit tick count from `urv_timer`, matches it against a software-written 40-bit compare value, and raises a level interrupt that is held until acknowledged. In periodic mode it re-arms itself by adding a reload period, and it counts overruns when events are missed. It sits between `urv_timer` (`csr_time_o`) and the core's interrupt/CSR logic.

---
 rtl/urv_timer_irq_pkg.sv | 25 ++
 rtl/urv_timer_irq.sv | 132 +++++++++++++
 tb/tb_urv_timer_irq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/urv_timer_irq_pkg.sv
// Shared encodings for the timer compare/interrupt controller: CSR selects,
// CTRL bit positions, FSM states and the compare reset value.
package urv_timer_irq_pkg;

  typedef enum logic [1:0] {
    SelCmpLo  = 2'd0,
    SelCmpHi  = 2'd1,
    SelPeriod = 2'd2,
    SelCtrl   = 2'd3
  } csr_sel_e;

  localparam int unsigned CtrlEnBit       = 0;
  localparam int unsigned CtrlPeriodicBit = 1;
  localparam int unsigned CtrlPendingBit  = 2;
  localparam int unsigned CtrlOvrLsb      = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StPending = 2'd2
  } state_e;

  localparam logic [39:0] CmpRstVal = 40'hFF_FFFF_FFFF;

endpackage

// File: rtl/urv_timer_irq.sv
// Timer compare/interrupt controller: matches a 40-bit tick count against CMP,
// raises a held level interrupt, optionally re-arms by PERIOD and counts overruns.
module urv_timer_irq
  import urv_timer_irq_pkg::*;
#(
  parameter int unsigned g_ovr_width = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [39:0] time_i,
  input  logic [1:0]  csr_sel_i,
  input  logic        csr_we_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  input  logic        irq_ack_i,
  output logic        irq_o
);

  state_e                 state_q, state_d;
  logic [39:0]            cmp_q, cmp_d;
  logic [31:0]            shadow_q, shadow_d;
  logic [31:0]            period_q, period_d;
  logic                   en_q, en_d;
  logic                   periodic_q, periodic_d;
  logic [g_ovr_width-1:0] ovr_q, ovr_d;
  logic                   irq_q;

  csr_sel_e    sel;
  logic        match;
  logic        reload;
  logic        ctrl_wr;
  logic [39:0] cmp_adv;

  assign sel     = csr_sel_e'(csr_sel_i);
  assign match   = (time_i >= cmp_q);
  assign reload  = periodic_q && (period_q != 32'd0);
  assign ctrl_wr = csr_we_i && (sel == SelCtrl);
  assign cmp_adv = cmp_q + {8'd0, period_q};

  always_comb begin
    state_d    = state_q;
    cmp_d      = cmp_q;
    shadow_d   = shadow_q;
    period_d   = period_q;
    en_d       = en_q;
    periodic_d = periodic_q;
    ovr_d      = ovr_q;

    // A CTRL write in the same cycle suppresses any match-driven transition.
    if (!ctrl_wr) begin
      case (state_q)
        StArmed: begin
          if (match) begin
            state_d = StPending;
            if (reload) cmp_d = cmp_adv;
          end
        end
        StPending: begin
          if (irq_ack_i) begin
            if (reload) begin
              if (match) cmp_d = cmp_adv;
              else       state_d = StArmed;
            end else begin
              state_d = StIdle;
              en_d    = 1'b0;
            end
          end else if (match && reload) begin
            cmp_d = cmp_adv;
            if (!(&ovr_q)) ovr_d = ovr_q + g_ovr_width'(1);
          end
        end
        default: ;
      endcase
    end

    // CSR writes are applied last so they override the datapath updates above.
    if (csr_we_i) begin
      unique case (sel)
        SelCmpLo:  shadow_d = csr_wdata_i;
        SelCmpHi:  cmp_d    = {csr_wdata_i[7:0], shadow_q};
        SelPeriod: period_d = csr_wdata_i;
        SelCtrl: begin
          en_d       = csr_wdata_i[CtrlEnBit];
          periodic_d = csr_wdata_i[CtrlPeriodicBit];
          ovr_d      = '0;
          if (!csr_wdata_i[CtrlEnBit])  state_d = StIdle;
          else if (state_q == StIdle)   state_d = StArmed;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      cmp_q      <= CmpRstVal;
      shadow_q   <= 32'd0;
      period_q   <= 32'd0;
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      ovr_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmp_q      <= cmp_d;
      shadow_q   <= shadow_d;
      period_q   <= period_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      ovr_q      <= ovr_d;
      irq_q      <= (state_d == StPending);
    end
  end

  assign irq_o = irq_q;

  always_comb begin
    csr_rdata_o = 32'd0;
    unique case (sel)
      SelCmpLo:  csr_rdata_o = cmp_q[31:0];
      SelCmpHi:  csr_rdata_o = {24'd0, cmp_q[39:32]};
      SelPeriod: csr_rdata_o = period_q;
      SelCtrl: begin
        csr_rdata_o[CtrlEnBit]                  = en_q;
        csr_rdata_o[CtrlPeriodicBit]            = periodic_q;
        csr_rdata_o[CtrlPendingBit]             = (state_q == StPending);
        csr_rdata_o[CtrlOvrLsb +: g_ovr_width]  = ovr_q;
      end
    endcase
  end

endmodule

// File: tb/tb_urv_timer_irq.sv
// Directed bench for urv_timer_irq: a vector table for the one-shot flow plus
// hand-written sequences for periodic, overrun, atomic commit and races.
module tb_urv_timer_irq;

  logic        clk;
  logic        rst;
  logic [39:0] time_v;
  logic [1:0]  csr_sel;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        irq_ack;
  logic        irq;

  int unsigned n_pass;
  int unsigned n_total;

  localparam logic [1:0] CmpLo = 2'd0, CmpHi = 2'd1, Period = 2'd2, Ctrl = 2'd3;

  urv_timer_irq #(.g_ovr_width(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .time_i     (time_v),
    .csr_sel_i  (csr_sel),
    .csr_we_i   (csr_we),
    .csr_wdata_i(csr_wdata),
    .csr_rdata_o(csr_rdata),
    .irq_ack_i  (irq_ack),
    .irq_o      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [31:0] wdata;
    logic        ack;
    logic [39:0] t;
    logic [1:0]  rsel;
    logic        exp_irq;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  // Drive one cycle of inputs, clock it, then release the strobes.
  task automatic cyc(input logic we, input logic [1:0] sel, input logic [31:0] wd,
                     input logic ack, input logic [39:0] t);
    csr_we    = we;
    csr_sel   = sel;
    csr_wdata = wd;
    irq_ack   = ack;
    time_v    = t;
    @(posedge clk);
    #1;
    csr_we  = 1'b0;
    irq_ack = 1'b0;
  endtask

  task automatic rd(input string name, input logic [1:0] sel, input logic [31:0] exp);
    csr_sel = sel;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic setup_cmp(input logic [31:0] cmp, input logic [39:0] t);
    cyc(1'b1, CmpLo, cmp, 1'b0, t);
    cyc(1'b1, CmpHi, 32'd0, 1'b0, t);
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b0;
    time_v    = 40'd0;
    csr_sel   = CmpLo;
    csr_we    = 1'b0;
    csr_wdata = 32'd0;
    irq_ack   = 1'b0;

    // Reset state
    do_reset();
    #1;
    chk("reset_irq", {31'd0, irq}, 32'd0);
    rd("reset_ctrl", Ctrl, 32'd0);
    rd("reset_cmp_lo", CmpLo, 32'hFFFF_FFFF);
    rd("reset_cmp_hi", CmpHi, 32'h0000_00FF);
    rd("reset_period", Period, 32'd0);

    // One-shot flow: {we, sel, wdata, ack, time, rsel, exp_irq, exp_rdata}
    vecs[0] = '{1'b1, CmpLo, 32'd100, 1'b0, 40'd0,   CmpLo, 1'b0, 32'hFFFF_FFFF};
    vecs[1] = '{1'b1, CmpHi, 32'd0,   1'b0, 40'd0,   CmpLo, 1'b0, 32'd100};
    vecs[2] = '{1'b1, Ctrl,  32'd1,   1'b0, 40'd0,   Ctrl,  1'b0, 32'h1};
    vecs[3] = '{1'b0, Ctrl,  32'd0,   1'b0, 40'd99,  Ctrl,  1'b0, 32'h1};
    vecs[4] = '{1'b0, Ctrl,  32'd0,   1'b0, 40'd100, Ctrl,  1'b1, 32'h5};
    vecs[5] = '{1'b0, Ctrl,  32'd0,   1'b0, 40'd101, Ctrl,  1'b1, 32'h5};
    vecs[6] = '{1'b0, Ctrl,  32'd0,   1'b1, 40'd102, Ctrl,  1'b0, 32'h0};
    vecs[7] = '{1'b0, Ctrl,  32'd0,   1'b0, 40'd200, Ctrl,  1'b0, 32'h0};
    vecs[8] = '{1'b0, Ctrl,  32'd0,   1'b0, 40'd201, CmpLo, 1'b0, 32'd100};
    for (int i = 0; i < 9; i++) begin
      cyc(vecs[i].we, vecs[i].sel, vecs[i].wdata, vecs[i].ack, vecs[i].t);
      chk($sformatf("oneshot_irq[%0d]", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
      rd($sformatf("oneshot_rd[%0d]", i), vecs[i].rsel, vecs[i].exp_rdata);
    end

    // Periodic: irq at 10, 15, 20, 25, ack two cycles after each rise
    do_reset();
    setup_cmp(32'd10, 40'd0);
    cyc(1'b1, Period, 32'd5, 1'b0, 40'd0);
    cyc(1'b1, Ctrl, 32'd3, 1'b0, 40'd0);
    for (int t = 1; t <= 27; t++) begin
      logic ack_now;
      logic exp_i;
      ack_now = (t == 12) || (t == 17) || (t == 22) || (t == 27);
      exp_i = (t == 10) || (t == 11) || (t == 15) || (t == 16) ||
              (t == 20) || (t == 21) || (t == 25) || (t == 26);
      cyc(1'b0, Ctrl, 32'd0, ack_now, 40'(t));
      chk($sformatf("periodic_irq_t%0d", t), {31'd0, irq}, {31'd0, exp_i});
    end
    rd("periodic_ctrl_ovr0", Ctrl, 32'h3);
    rd("periodic_cmp_next", CmpLo, 32'd30);

    // Overrun: ack withheld until time 23
    do_reset();
    setup_cmp(32'd10, 40'd0);
    cyc(1'b1, Period, 32'd5, 1'b0, 40'd0);
    cyc(1'b1, Ctrl, 32'd3, 1'b0, 40'd0);
    for (int t = 1; t <= 22; t++) begin
      cyc(1'b0, Ctrl, 32'd0, 1'b0, 40'(t));
      chk($sformatf("overrun_irq_t%0d", t), {31'd0, irq}, {31'd0, (t >= 10)});
    end
    rd("overrun_ctrl_pre_ack", Ctrl, 32'h0000_0207);
    cyc(1'b0, Ctrl, 32'd0, 1'b1, 40'd23);
    chk("overrun_irq_after_ack", {31'd0, irq}, 32'd0);
    rd("overrun_ctrl", Ctrl, 32'h0000_0203);
    rd("overrun_cmp", CmpLo, 32'd25);
    cyc(1'b1, Ctrl, 32'd3, 1'b0, 40'd24);
    rd("overrun_cleared", Ctrl, 32'h3);

    // Atomic commit: CMP_LO alone must not change the live compare
    do_reset();
    setup_cmp(32'd1000, 40'd500);
    cyc(1'b1, Ctrl, 32'd1, 1'b0, 40'd500);
    cyc(1'b1, CmpLo, 32'd50, 1'b0, 40'd500);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, CmpLo, 32'd0, 1'b0, 40'd500);
      chk($sformatf("atomic_hold_irq[%0d]", i), {31'd0, irq}, 32'd0);
    end
    rd("atomic_cmp_unchanged", CmpLo, 32'd1000);
    cyc(1'b1, CmpHi, 32'd0, 1'b0, 40'd500);
    chk("atomic_commit_edge_irq", {31'd0, irq}, 32'd0);
    rd("atomic_cmp_committed", CmpLo, 32'd50);
    cyc(1'b0, CmpLo, 32'd0, 1'b0, 40'd500);
    chk("atomic_fire_irq", {31'd0, irq}, 32'd1);

    // Race: EN=0 CTRL write in the match cycle
    do_reset();
    setup_cmp(32'd10, 40'd0);
    cyc(1'b1, Ctrl, 32'd1, 1'b0, 40'd9);
    cyc(1'b1, Ctrl, 32'd0, 1'b0, 40'd10);
    chk("race_dis_irq0", {31'd0, irq}, 32'd0);
    for (int t = 11; t <= 13; t++) begin
      cyc(1'b0, Ctrl, 32'd0, 1'b0, 40'(t));
      chk($sformatf("race_dis_irq_t%0d", t), {31'd0, irq}, 32'd0);
    end
    rd("race_dis_ctrl", Ctrl, 32'h0);

    // Race: async reset asserted while pending
    do_reset();
    setup_cmp(32'd10, 40'd0);
    cyc(1'b1, Ctrl, 32'd1, 1'b0, 40'd5);
    cyc(1'b0, Ctrl, 32'd0, 1'b0, 40'd10);
    chk("rst_pending_irq_before", {31'd0, irq}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_pending_irq_async", {31'd0, irq}, 32'd0);
    rd("rst_pending_ctrl", Ctrl, 32'h0);
    rd("rst_pending_cmp", CmpLo, 32'hFFFF_FFFF);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, Ctrl, 32'd0, 1'b0, 40'd11);
    chk("rst_pending_stays_idle", {31'd0, irq}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
